// File: rtl/ifu_fetch.sv
// Instruction fetch unit: AXI-lite read master that fetches one instruction at a time
// and hands {inst, pc, fault} to decode, then waits for the committed next PC.
module ifu_fetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              awvalid,
  output logic              wvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              npc_valid,
  input  logic [ADDR_W-1:0] npc,
  output logic [31:0]       fetch_cnt
);

  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    RDATA    = 3'd2,
    DELIVER  = 3'd3,
    WAIT_NPC = 3'd4
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst_reg;
  logic              fault_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     next_state = FETCH;
      FETCH:    if (arready)    next_state = RDATA;
      RDATA:    if (rvalid)     next_state = DELIVER;
      DELIVER:  if (inst_ready) next_state = WAIT_NPC;
      WAIT_NPC: if (npc_valid)  next_state = FETCH;
      default:  next_state = IDLE;
    endcase
  end

  // npc_valid outside WAIT_NPC is dropped; pc only moves on a legal redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      inst_reg  <= NOP;
      fault_reg <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      unique case (state)
        RDATA: if (rvalid) begin
          inst_reg  <= rdata;
          fault_reg <= (rresp != 2'b00);
        end
        DELIVER:  if (inst_ready) fetch_cnt <= fetch_cnt + 32'd1;
        WAIT_NPC: if (npc_valid)  pc <= {npc[ADDR_W-1:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_comb begin
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    inst_fault = 1'b0;
    unique case (state)
      FETCH:   arvalid = 1'b1;
      RDATA:   rready  = 1'b1;
      DELIVER: begin
        inst_valid = 1'b1;
        inst_fault = fault_reg;
      end
      default: ;
    endcase
  end

  assign araddr  = pc;
  assign inst    = inst_reg;
  assign inst_pc = pc;

  assign awvalid = 1'b0;
  assign wvalid  = 1'b0;
  assign bready  = 1'b0;
  assign awaddr  = '0;
  assign wdata   = '0;
  assign wstrb   = '0;

  always_ff @(posedge clk) begin
    if (rst_n && npc_valid)
      assert (state == WAIT_NPC)
        else $warning("ifu_fetch: npc_valid outside WAIT_NPC ignored");
  end

endmodule
